// File: rtl/om_pkg.sv
// ---------------------------------------------------------------------------
// om_pkg
// Shared types for the object-memory access checker.
//   om_code_e      : response classification (OK / OVERFLOW / GUARD / UNDERFLOW)
//   om_chk_state_e : checker FSM states
//   OM_ADDR_W      : default address width, matches the range buffer
//   om_classify()  : priority classification of the two probe results
// ---------------------------------------------------------------------------
package om_pkg;

  localparam int OM_ADDR_W = 32;

  typedef enum logic [1:0] {
    OM_OK        = 2'b00,
    OM_OVERFLOW  = 2'b01,
    OM_GUARD     = 2'b10,
    OM_UNDERFLOW = 2'b11
  } om_code_e;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'b00,
    CHK_FIRST = 2'b01,
    CHK_LAST  = 2'b10,
    CHK_RESP  = 2'b11
  } om_chk_state_e;

  // Guard dominates; a range mismatch between the first and last byte tells
  // us which side of the object the access spilled over. Both in range or
  // both untracked is treated as a legal access.
  function automatic om_code_e om_classify(input logic guard,
                                           input logic inFirst,
                                           input logic inLast);
    om_code_e code;
    if (guard)                 code = OM_GUARD;
    else if (inFirst && !inLast) code = OM_OVERFLOW;
    else if (!inFirst && inLast) code = OM_UNDERFLOW;
    else                       code = OM_OK;
    return code;
  endfunction

endpackage

// File: rtl/om_fault_log.sv
// ---------------------------------------------------------------------------
// om_fault_log
// Violation log for the access checker: sticky flag, address of the most
// recent violation and a saturating violation counter.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : wipe the log
//   record_i       : a violation is being reported this cycle
//   rec_addr_i     : request address of that violation
//   fault_o        : sticky violation flag
//   fault_addr_o   : address of the most recent violation
//   fault_cnt_o    : saturating violation count
// ---------------------------------------------------------------------------
module om_fault_log #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              record_i,
  input  logic [ADDR_W-1:0] rec_addr_i,
  output logic              fault_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic [CNT_W-1:0]  fault_cnt_o
);

  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] faultAddr_q, faultAddr_d;
  logic [CNT_W-1:0]  faultCnt_q, faultCnt_d;

  // A violation arriving together with a clear wins: the log restarts with
  // this violation as its only entry rather than being wiped.
  always_comb begin
    fault_d     = fault_q;
    faultAddr_d = faultAddr_q;
    faultCnt_d  = faultCnt_q;
    if (record_i) begin
      fault_d     = 1'b1;
      faultAddr_d = rec_addr_i;
      if (clear_i)          faultCnt_d = CNT_W'(1);
      else if (&faultCnt_q) faultCnt_d = faultCnt_q;
      else                  faultCnt_d = faultCnt_q + CNT_W'(1);
    end else if (clear_i) begin
      fault_d     = 1'b0;
      faultAddr_d = '0;
      faultCnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q     <= 1'b0;
      faultAddr_q <= '0;
      faultCnt_q  <= '0;
    end else begin
      fault_q     <= fault_d;
      faultAddr_q <= faultAddr_d;
      faultCnt_q  <= faultCnt_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = faultAddr_q;
  assign fault_cnt_o  = faultCnt_q;

endmodule

// File: rtl/om_access_checker.sv
// ---------------------------------------------------------------------------
// om_access_checker
// Classifies LSU accesses against the object-memory range buffer by probing
// the first and last byte of each access, and logs violations.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   en_i                          : checking enable, sampled at accept
//   clear_i                       : clears the fault log
//   req_valid_i/req_ready_o       : request handshake
//   req_addr_i/req_size_i/req_we_i: byte address, log2 size, store flag
//   find_o/find_addr_o            : probe strobe/address to the range buffer
//   addr_in_range_i/addr_is_first_i: combinational range buffer result
//   resp_valid_o/resp_ok_o/resp_code_o : single-cycle response
//   fault_o/fault_addr_o/fault_cnt_o   : violation log
// ---------------------------------------------------------------------------
module om_access_checker
  import om_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = OM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_we_i,
  output logic [ADDR_W-1:0] find_addr_o,
  output logic              find_o,
  input  logic              addr_in_range_i,
  input  logic              addr_is_first_i,
  output logic              resp_valid_o,
  output logic              resp_ok_o,
  output logic [1:0]        resp_code_o,
  output logic              fault_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic [CNT_W-1:0]  fault_cnt_o
);

  om_chk_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [ADDR_W:0]   last_q;
  logic              inFirst_q;
  logic              guard_q;
  logic              ready_q;
  logic              find_q;
  logic [ADDR_W-1:0] findAddr_q;
  logic              respValid_q;
  logic              respOk_q;
  om_code_e          respCode_q;

  logic [ADDR_W:0]   reqLast_d;
  logic              inLast_d;
  om_code_e          code_d;
  logic              record_d;

  // Last byte is kept one bit wider so an access running past the top of
  // the address space is visible as a carry instead of silently wrapping.
  assign reqLast_d = {1'b0, req_addr_i}
                   + ({{ADDR_W{1'b0}}, 1'b1} << req_size_i)
                   - {{ADDR_W{1'b0}}, 1'b1};

  // A wrapped last byte cannot belong to the same object as the first byte.
  assign inLast_d = addr_in_range_i & ~last_q[ADDR_W];
  assign code_d   = om_classify(guard_q, inFirst_q, inLast_d);

  // Outputs are registered, so each state sets up the outputs of the state
  // it moves into: the probe address for CHK_FIRST is loaded at accept, the
  // last-byte address while in CHK_FIRST, and the response while in CHK_LAST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CHK_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      last_q      <= '0;
      inFirst_q   <= 1'b0;
      guard_q     <= 1'b0;
      ready_q     <= 1'b1;
      find_q      <= 1'b0;
      findAddr_q  <= '0;
      respValid_q <= 1'b0;
      respOk_q    <= 1'b0;
      respCode_q  <= OM_OK;
    end else begin
      case (state_q)
        CHK_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            last_q  <= reqLast_d;
            ready_q <= 1'b0;
            if (en_i) begin
              state_q    <= CHK_FIRST;
              find_q     <= 1'b1;
              findAddr_q <= req_addr_i;
            end else begin
              state_q     <= CHK_RESP;
              respValid_q <= 1'b1;
              respOk_q    <= 1'b1;
              respCode_q  <= OM_OK;
            end
          end
        end
        CHK_FIRST: begin
          inFirst_q  <= addr_in_range_i;
          guard_q    <= addr_is_first_i & we_q;
          findAddr_q <= last_q[ADDR_W-1:0];
          state_q    <= CHK_LAST;
        end
        CHK_LAST: begin
          find_q      <= 1'b0;
          findAddr_q  <= '0;
          respValid_q <= 1'b1;
          respOk_q    <= (code_d == OM_OK);
          respCode_q  <= code_d;
          state_q     <= CHK_RESP;
        end
        CHK_RESP: begin
          respValid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= CHK_IDLE;
        end
        default: state_q <= CHK_IDLE;
      endcase
    end
  end

  // The response is consumed in its only cycle, so that cycle is the one in
  // which a violation is committed to the log.
  assign record_d = respValid_q & (respCode_q != OM_OK);

  om_fault_log #(
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) u_fault_log (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .record_i    (record_d),
    .rec_addr_i  (addr_q),
    .fault_o     (fault_o),
    .fault_addr_o(fault_addr_o),
    .fault_cnt_o (fault_cnt_o)
  );

  assign req_ready_o  = ready_q;
  assign find_o       = find_q;
  assign find_addr_o  = findAddr_q;
  assign resp_valid_o = respValid_q;
  assign resp_ok_o    = respOk_q;
  assign resp_code_o  = respCode_q;

endmodule

// File: tb/tb_om_access_checker.sv
// ---------------------------------------------------------------------------
// tb_om_access_checker
// Self-checking bench: a behavioural range buffer (list of small objects)
// answers the probes, and an address-arithmetic reference model predicts the
// classification, timing, probe addresses and fault log of every request.
// ---------------------------------------------------------------------------
module tb_om_access_checker;

  localparam int CNT_W  = 2;
  localparam int ADDR_W = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i;
  logic              rst_ni;
  logic              en_i;
  logic              clear_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_size_i;
  logic              req_we_i;
  logic [ADDR_W-1:0] find_addr_o;
  logic              find_o;
  logic              addr_in_range_i;
  logic              addr_is_first_i;
  logic              resp_valid_o;
  logic              resp_ok_o;
  logic [1:0]        resp_code_o;
  logic              fault_o;
  logic [ADDR_W-1:0] fault_addr_o;
  logic [CNT_W-1:0]  fault_cnt_o;

  om_access_checker #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .clear_i        (clear_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_we_i       (req_we_i),
    .find_addr_o    (find_addr_o),
    .find_o         (find_o),
    .addr_in_range_i(addr_in_range_i),
    .addr_is_first_i(addr_is_first_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ok_o      (resp_ok_o),
    .resp_code_o    (resp_code_o),
    .fault_o        (fault_o),
    .fault_addr_o   (fault_addr_o),
    .fault_cnt_o    (fault_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Range buffer contents: every entry is a small object [first,last].
  logic [31:0] entFirst[4];
  logic [31:0] entLast[4];
  int          entN = 0;

  function automatic bit inRangeF(input logic [31:0] a);
    for (int i = 0; i < entN; i++)
      if (a >= entFirst[i] && a <= entLast[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit isFirstF(input logic [31:0] a);
    for (int i = 0; i < entN; i++)
      if (a == entFirst[i]) return 1'b1;
    return 1'b0;
  endfunction

  always_comb begin
    addr_in_range_i = find_o && inRangeF(find_addr_o);
    addr_is_first_i = find_o && isFirstF(find_addr_o);
  end

  // Reference classification from the access's byte span.
  function automatic logic [1:0] expCode(input logic [31:0] a, input logic [1:0] sz,
                                         input logic w);
    longint unsigned endB;
    bit f, l, g;
    endB = longint'(a) + (longint'(1) << sz) - 1;
    f = inRangeF(a);
    l = (endB <= 64'hFFFF_FFFF) && inRangeF(endB[31:0]);
    g = w && isFirstF(a);
    if (g) return 2'b10;
    if (f && !l) return 2'b01;
    if (!f && l) return 2'b11;
    return 2'b00;
  endfunction

  // Reference fault log.
  bit          mFault;
  logic [31:0] mAddr;
  int          mCnt;

  // Results captured by runReq.
  logic [1:0]  gotCode;
  logic        gotOk;
  int          lat, readyLow, probeCnt;
  logic [31:0] probeAddr[4];
  bit          timedOut;
  logic        readyAfter;
  logic [1:0]  mCode;

  // Drives one request starting at a negedge with the DUT idle, waits (bounded)
  // for the response and ends on the negedge after it. Expected log is updated.
  task automatic runReq(input logic [31:0] a, input logic [1:0] sz, input logic w,
                        input logic e, input bit flipEn, input bit clrAtResp);
    req_addr_i  = a;
    req_size_i  = sz;
    req_we_i    = w;
    en_i        = e;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (flipEn) en_i = ~e;
    lat = 1; readyLow = 0; probeCnt = 0; timedOut = 0;
    gotCode = 2'bxx; gotOk = 1'bx;
    while (1) begin
      if (!req_ready_o) readyLow++;
      if (find_o) begin
        if (probeCnt < 4) probeAddr[probeCnt] = find_addr_o;
        probeCnt++;
      end
      if (resp_valid_o) begin
        gotCode = resp_code_o;
        gotOk   = resp_ok_o;
        break;
      end
      if (lat >= 10) begin
        timedOut = 1;
        break;
      end
      @(negedge clk_i);
      lat++;
    end
    if (clrAtResp) clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    readyAfter = req_ready_o;
    mCode = e ? expCode(a, sz, w) : 2'b00;
    if (mCode != 2'b00) begin
      mFault = 1;
      mAddr  = a;
      mCnt   = clrAtResp ? 1 : ((mCnt == CNT_MAX) ? CNT_MAX : mCnt + 1);
    end else if (clrAtResp) begin
      mFault = 0; mAddr = 0; mCnt = 0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 0; clear_i = 0; req_valid_i = 0;
    req_addr_i = 0; req_size_i = 0; req_we_i = 0;
    repeat (2) @(negedge clk_i);
    tests++;
    if ({req_ready_o, resp_valid_o, resp_ok_o, resp_code_o, find_o, find_addr_o,
         fault_o, fault_addr_o, fault_cnt_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,
         1'b0, 32'h0, 2'b00}) begin
      fails++;
      $display("[TB] FAIL reset_values got ready=%b rv=%b ok=%b code=%b find=%b fa=%h f=%b faddr=%h cnt=%0d want 1 0 0 00 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_ok_o, resp_code_o, find_o, find_addr_o,
               fault_o, fault_addr_o, fault_cnt_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    mFault = 0; mAddr = 0; mCnt = 0;
  endtask

  task automatic test_directed();
    entN = 1; entFirst[0] = 32'h1000; entLast[0] = 32'h10FF;
    // In-range load
    runReq(32'h1010, 2'd2, 1'b0, 1'b1, 0, 0);
    tests++;
    if (timedOut || lat != 3) begin
      fails++; $display("[TB] FAIL load_latency got %0d (timeout=%0d) want 3", lat, timedOut);
    end
    tests++;
    if (probeCnt != 2 || probeAddr[0] !== 32'h1010 || probeAddr[1] !== 32'h1013) begin
      fails++; $display("[TB] FAIL load_probes got n=%0d %h %h want 2 00001010 00001013",
                        probeCnt, probeAddr[0], probeAddr[1]);
    end
    tests++;
    if ({gotCode, gotOk, fault_o} !== 4'b0010) begin
      fails++; $display("[TB] FAIL load_ok got code=%b ok=%b fault=%b want 00 1 0", gotCode, gotOk, fault_o);
    end
    // Overflow store
    runReq(32'h10FE, 2'd2, 1'b1, 1'b1, 0, 0);
    tests++;
    if ({gotCode, gotOk, fault_o, fault_addr_o, fault_cnt_o} !== {2'b01, 1'b0, 1'b1, 32'h10FE, 2'd1}) begin
      fails++; $display("[TB] FAIL overflow got code=%b ok=%b f=%b fa=%h cnt=%0d want 01 0 1 000010fe 1",
                        gotCode, gotOk, fault_o, fault_addr_o, fault_cnt_o);
    end
    // Guard store vs. plain load of the first byte
    runReq(32'h1000, 2'd0, 1'b1, 1'b1, 0, 0);
    tests++;
    if (gotCode !== 2'b10 || probeAddr[1] !== 32'h1000) begin
      fails++; $display("[TB] FAIL guard got code=%b probe2=%h want 10 00001000", gotCode, probeAddr[1]);
    end
    runReq(32'h1000, 2'd0, 1'b0, 1'b1, 0, 0);
    tests++;
    if (gotCode !== 2'b00) begin
      fails++; $display("[TB] FAIL load_first got code=%b want 00", gotCode);
    end
    // Underflow
    runReq(32'h0FFE, 2'd2, 1'b0, 1'b1, 0, 0);
    tests++;
    if ({gotCode, fault_cnt_o} !== {2'b11, 2'd3}) begin
      fails++; $display("[TB] FAIL underflow got code=%b cnt=%0d want 11 3", gotCode, fault_cnt_o);
    end
    // Wrap past the top of memory
    entN = 2; entFirst[1] = 32'hFFFF_FF00; entLast[1] = 32'hFFFF_FFFF;
    runReq(32'hFFFF_FFFE, 2'd2, 1'b0, 1'b1, 0, 0);
    tests++;
    if ({gotCode, fault_addr_o, fault_cnt_o} !== {2'b01, 32'hFFFF_FFFE, 2'd3}) begin
      fails++; $display("[TB] FAIL wrap got code=%b fa=%h cnt=%0d want 01 fffffffe 3",
                        gotCode, fault_addr_o, fault_cnt_o);
    end
  endtask

  task automatic test_bypass();
    runReq(32'h10FE, 2'd2, 1'b1, 1'b0, 0, 0);
    tests++;
    if (timedOut || lat != 1 || probeCnt != 0 || readyLow != 1) begin
      fails++; $display("[TB] FAIL bypass_timing got lat=%0d probes=%0d readyLow=%0d want 1 0 1",
                        lat, probeCnt, readyLow);
    end
    tests++;
    if ({gotCode, gotOk, fault_o, fault_addr_o, fault_cnt_o} !== {2'b00, 1'b1, 1'b1, 32'hFFFF_FFFE, 2'd3}) begin
      fails++; $display("[TB] FAIL bypass_result got code=%b ok=%b f=%b fa=%h cnt=%0d want 00 1 1 fffffffe 3",
                        gotCode, gotOk, fault_o, fault_addr_o, fault_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      runReq(32'h1004 + 32'(i * 4), 2'd1, 1'b0, 1'b1, 0, 0);
      tests++;
      if (timedOut || readyLow != 3 || readyAfter !== 1'b1) begin
        fails++; $display("[TB] FAIL back_to_back_%0d got readyLow=%0d readyAfter=%b want 3 1",
                          i, readyLow, readyAfter);
      end
    end
  endtask

  task automatic test_saturate_clear();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    mFault = 0; mAddr = 0; mCnt = 0;
    tests++;
    if ({fault_o, fault_addr_o, fault_cnt_o} !== {1'b0, 32'h0, 2'd0}) begin
      fails++; $display("[TB] FAIL clear_alone got f=%b fa=%h cnt=%0d want 0 0 0",
                        fault_o, fault_addr_o, fault_cnt_o);
    end
    for (int i = 0; i < 5; i++) runReq(32'h10FE, 2'd2, 1'b1, 1'b1, 0, 0);
    tests++;
    if ({fault_o, fault_cnt_o} !== {1'b1, 2'd3}) begin
      fails++; $display("[TB] FAIL saturate got f=%b cnt=%0d want 1 3", fault_o, fault_cnt_o);
    end
    runReq(32'h0FFC, 2'd3, 1'b0, 1'b1, 0, 1);
    tests++;
    if ({gotCode, fault_o, fault_addr_o, fault_cnt_o} !== {2'b11, 1'b1, 32'h0FFC, 2'd1}) begin
      fails++; $display("[TB] FAIL clear_vs_record got code=%b f=%b fa=%h cnt=%0d want 11 1 00000ffc 1",
                        gotCode, fault_o, fault_addr_o, fault_cnt_o);
    end
  endtask

  task automatic test_reset_midflight();
    bit sawResp;
    req_addr_i = 32'h10FE; req_size_i = 2'd2; req_we_i = 1'b1; en_i = 1'b1;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({req_ready_o, resp_valid_o, resp_ok_o, resp_code_o, find_o, find_addr_o,
         fault_o, fault_addr_o, fault_cnt_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,
         1'b0, 32'h0, 2'b00}) begin
      fails++; $display("[TB] FAIL midflight_reset got ready=%b rv=%b find=%b fa=%h f=%b cnt=%0d want 1 0 0 0 0 0",
                        req_ready_o, resp_valid_o, find_o, find_addr_o, fault_o, fault_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    mFault = 0; mAddr = 0; mCnt = 0;
    sawResp = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (resp_valid_o || find_o) sawResp = 1;
    end
    tests++;
    if (sawResp) begin
      fails++; $display("[TB] FAIL midflight_no_resp got activity=1 want 0");
    end
  endtask

  task automatic test_random();
    logic [31:0] a, base, lastB;
    logic [1:0]  sz;
    logic        w, e;
    bit          flip, clr;
    int          k;
    for (int it = 0; it < 60; it++) begin
      if (it % 15 == 0) begin
        for (int i = 0; i < 3; i++) begin
          entFirst[i] = 32'h0010_0000 * 32'(i + 1) + (32'($urandom_range(0, 255)) << 4);
          entLast[i]  = entFirst[i] + 32'($urandom_range(0, 63));
        end
        entFirst[3] = 32'hFFFF_FF00 + 32'($urandom_range(0, 15)); entLast[3] = 32'hFFFF_FFFF;
        entN = 4;
      end
      k    = $urandom_range(0, 3);
      base = $urandom_range(0, 1) ? entFirst[k] : entLast[k];
      a    = base + 32'($urandom_range(0, 7)) - 32'd4;
      sz   = 2'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      e    = ($urandom_range(0, 3) != 0);
      flip = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 5) == 0);
      lastB = a + (32'd1 << sz) - 32'd1;
      runReq(a, sz, w, e, flip, clr);
      tests++;
      if (timedOut || gotCode !== mCode || gotOk !== (mCode == 2'b00)) begin
        fails++; $display("[TB] FAIL rand_code it=%0d a=%h sz=%0d we=%b en=%b got code=%b ok=%b to=%0d want %b",
                          it, a, sz, w, e, gotCode, gotOk, timedOut, mCode);
      end
      tests++;
      if (lat != (e ? 3 : 1) || readyLow != lat || probeCnt != (e ? 2 : 0) ||
          (e && (probeAddr[0] !== a || probeAddr[1] !== lastB))) begin
        fails++; $display("[TB] FAIL rand_timing it=%0d got lat=%0d readyLow=%0d probes=%0d p0=%h p1=%h want en=%b last=%h",
                          it, lat, readyLow, probeCnt, probeAddr[0], probeAddr[1], e, lastB);
      end
      tests++;
      if (fault_o !== mFault || fault_addr_o !== mAddr || fault_cnt_o !== CNT_W'(mCnt)) begin
        fails++; $display("[TB] FAIL rand_log it=%0d got f=%b fa=%h cnt=%0d want %b %h %0d",
                          it, fault_o, fault_addr_o, fault_cnt_o, mFault, mAddr, mCnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bypass();
    test_back_to_back();
    test_saturate_clear();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/om_access_checker.md
Name: om_access_checker

Overview:
- Query-side client of the object-memory range buffer: takes LSU load/store requests, probes the buffer for the access's first and last byte, and classifies each access.
- Classes: OK, OVERFLOW, GUARD (store to the first word of a small object) or UNDERFLOW.
- Sits between the LSU address stage and the range buffer's find port.
- Logs violations (sticky flag, address, saturating count) for the exception/CSR logic.

Parameters:
- CNT_W, 8, width of the saturating violation counter.
- ADDR_W, 32, address width; must match the range buffer's address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  checking enable; sampled at request accept
- clear_i  in  1  clears the fault log
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  ADDR_W  byte address of the access
- req_size_i  in  2  log2 of access bytes (0=1B, 1=2B, 2=4B, 3=8B)
- req_we_i  in  1  1=store, 0=load
- find_addr_o  out  ADDR_W  address driven to the range buffer
- find_o  out  1  probe strobe to the range buffer
- addr_in_range_i  in  1  buffer hit: address lies inside some [first,last]
- addr_is_first_i  in  1  buffer hit: address equals the first address of a small object
- resp_valid_o  out  1  response valid
- resp_ok_o  out  1  1 when resp_code_o==OK
- resp_code_o  out  2  00 OK, 01 OVERFLOW, 10 GUARD, 11 UNDERFLOW
- fault_o  out  1  sticky violation flag
- fault_addr_o  out  ADDR_W  req_addr of the most recent violation
- fault_cnt_o  out  CNT_W  saturating violation count

Behaviour:
- Reset values (async on rst_ni low):
  - State IDLE; req_ready_o=1; resp_valid_o=0; resp_ok_o=0; resp_code_o=00.
  - find_o=0; find_addr_o=0.
  - fault_o=0; fault_addr_o=0; fault_cnt_o=0.
- Reset asserted mid-operation aborts the in-flight request; no response is produced.
- FSM states: IDLE, CHK_FIRST, CHK_LAST, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, we, and last = addr + (1<<size) - 1, computed in ADDR_W+1 bits.
  - en_i=1: go to CHK_FIRST.
  - en_i=0: go to RESP with code OK; bypass latency is 1 cycle.
- CHK_FIRST:
  - find_o=1; find_addr_o=addr.
  - Register in_first=addr_in_range_i and guard=addr_is_first_i & we.
  - Next state CHK_LAST.
  - The range buffer is combinational; its result is sampled in the same cycle.
- CHK_LAST:
  - find_o=1; find_addr_o=last[ADDR_W-1:0].
  - in_last=addr_in_range_i, forced to 0 if last carried out of ADDR_W (wrap-around).
  - Classification, in priority order:
    - guard -> GUARD
    - in_first & ~in_last -> OVERFLOW
    - ~in_first & in_last -> UNDERFLOW
    - otherwise OK (both in range, or untracked memory)
  - Next state RESP.
- RESP:
  - resp_valid_o=1; req_ready_o=0; code held stable until resp_ready handshake.
  - Implicit resp_ready: the response is consumed in the RESP cycle (single-cycle pulse); next state IDLE.
  - With en_i=1, a request accepted at cycle 0 has resp_valid_o high in cycle 3.
  - Throughput: one request per 4 cycles.
- find_o=0 and find_addr_o=0 in IDLE and RESP.
- 1B access: last==addr; both probes hit the same address; guard still applies on the first probe.
- Fault log, updated in the RESP cycle when code != OK:
  - fault_o<=1; fault_addr_o<=request addr; fault_cnt_o increments, saturating at all-ones.
- clear_i:
  - Alone: fault_o, fault_addr_o and fault_cnt_o go to 0.
  - Same cycle as a violation: the violation wins (fault_o=1, addr recorded, cnt=1).
- en_i toggling mid-request has no effect on that request.

Decomposition:
- Package om_pkg: om_code_e (OK, OVERFLOW, GUARD, UNDERFLOW, 2 bits); om_chk_state_e; localparam OM_ADDR_W=32.
- One sub-module, om_fault_log: sticky flag, address register and saturating counter with clear/record priority.

Test Plan:
- Buffer model with one small entry [0x1000,0x10FF]. Load 0x1010, size=2, en=1 -> find_addr 0x1010 then 0x1013; cycle 3 resp_valid=1, code 00, resp_ok=1, fault_o=0.
- Store 0x10FE, size=2 -> last 0x1101 out of range -> code 01, fault_o=1, fault_addr_o=0x10FE, fault_cnt_o=1.
- Store 0x1000, size=0 -> code 10 (GUARD). Load 0x1000, size=0 -> code 00.
- Access 0x0FFE, size=2 -> code 11. Access 0xFFFFFFFE, size=2 with entry [0xFFFFFF00,0xFFFFFFFF] -> wrap forces in_last=0 -> code 01.
- en_i=0, store 0x10FE -> resp in cycle 1, code 00, find_o never asserted, log unchanged. Back-to-back requests -> req_ready_o low for exactly 3 cycles each.
- CNT_W=2: five violations -> fault_cnt_o saturates at 3. clear_i coincident with a 6th violation -> cnt=1, fault_o=1. rst_ni pulse during CHK_LAST -> resp_valid_o stays 0, all outputs at reset values.
